// File: rtl/spi_flash_pkg.sv
// Shared constants for the SPI-flash read sequencer and its Wishbone access engine.
package spi_flash_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;

  // Bit positions inside the status/control payload byte
  localparam int unsigned ST_SS       = 0;
  localparam int unsigned ST_RX_EMPTY = 1;
  localparam int unsigned ST_TX_FULL  = 2;

  localparam logic [3:0] SEL_BYTE3 = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SS_LO,
    S_TX,
    S_POLL,
    S_RX,
    S_OUT,
    S_SS_HI,
    S_DONE
  } state_e;

endpackage

// File: rtl/spi_wb_access.sv
// Single-access Wishbone master: one registered strobe per request, ack pulse on completion,
// and a forced idle cycle after every access so a toggling slave ack is never seen twice.
module spi_wb_access
  import spi_flash_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req,
  input  logic               we,
  input  logic [1:0]         adr,
  input  logic [BYTE_W-1:0]  wr_byte,
  output logic               ack,
  output logic [BYTE_W-1:0]  rdata,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic [1:0]         m_adr_o,
  output logic               m_we_o,
  output logic [31:0]        m_dat_o,
  output logic [3:0]         m_sel_o,
  input  logic               m_ack_i,
  input  logic [31:0]        m_dat_i
);

  logic unused_dat;
  assign unused_dat = ^m_dat_i[23:0];

  assign m_sel_o = SEL_BYTE3;

  // ack doubles as the idle-cycle guard: the requester still holds req while it sees ack
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
    end else begin
      ack <= 1'b0;
      if (m_stb_o) begin
        if (m_ack_i) begin
          m_cyc_o <= 1'b0;
          m_stb_o <= 1'b0;
          m_we_o  <= 1'b0;
          ack     <= 1'b1;
          rdata   <= m_dat_i[31:24];
        end
      end else if (req && !ack) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= we;
        m_adr_o <= adr;
        m_dat_o <= {wr_byte, 24'h000000};
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI-flash READ sequencer: drives wb_spi through chip select, command/address/dummy bytes,
// status polling and RX draining, streaming data bytes out with valid/ready.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter int unsigned ADDR_BYTES = 3,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned POLL_MAX   = 1023
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [7:0]       dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             m_cyc_o,
  output logic             m_stb_o,
  output logic [1:0]       m_adr_o,
  output logic             m_we_o,
  output logic [31:0]      m_dat_o,
  output logic [3:0]       m_sel_o,
  input  logic             m_ack_i,
  input  logic [31:0]      m_dat_i
);

  localparam int unsigned HDR_BYTES = 1 + ADDR_BYTES;
  localparam int unsigned HDR_W     = BYTE_W * HDR_BYTES;
  localparam int unsigned CNT_W     = LEN_W + 3;
  localparam int unsigned POLL_W    = $clog2(POLL_MAX + 1);

  state_e             state_q, state_d;
  logic [HDR_W-1:0]   hdr_q;
  logic [CNT_W-1:0]   rem_q;
  logic [LEN_W-1:0]   len_q;
  logic [POLL_W-1:0]  poll_q;

  logic               acc_req, acc_we, acc_ack;
  logic [1:0]         acc_adr;
  logic [BYTE_W-1:0]  acc_byte, acc_rdata;

  logic accept, data_phase, rx_empty, poll_last, out_fire;
  logic unused_addr;

  assign unused_addr = ^addr_i;
  assign accept      = (state_q == S_IDLE) && start_i;
  assign data_phase  = rem_q <= CNT_W'(len_q);
  assign rx_empty    = acc_rdata[ST_RX_EMPTY];
  assign poll_last   = poll_q == POLL_W'(POLL_MAX - 1);
  assign out_fire    = dout_valid_o && dout_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = (len_i == '0) ? S_DONE : S_SS_LO;
      S_SS_LO: if (acc_ack) state_d = S_TX;
      S_TX:    if (acc_ack) state_d = S_POLL;
      S_POLL: begin
        if (acc_ack) begin
          if (!rx_empty)      state_d = S_RX;
          else if (poll_last) state_d = S_SS_HI;
        end
      end
      S_RX:    if (acc_ack) state_d = data_phase ? S_OUT : S_TX;
      S_OUT:   if (out_fire) state_d = (rem_q == CNT_W'(1)) ? S_SS_HI : S_TX;
      S_SS_HI: if (acc_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus request presented to the access engine for the current state
  always_comb begin
    acc_req  = 1'b0;
    acc_we   = 1'b0;
    acc_adr  = REG_DATA;
    acc_byte = '0;
    case (state_q)
      S_SS_LO: begin acc_req = 1'b1; acc_we = 1'b1; acc_adr = REG_CTRL; end
      S_TX: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_byte = hdr_q[HDR_W-1 -: BYTE_W];
      end
      S_POLL: begin acc_req = 1'b1; acc_adr = REG_CTRL; end
      S_RX:   acc_req = 1'b1;
      S_SS_HI: begin
        acc_req         = 1'b1;
        acc_we          = 1'b1;
        acc_adr         = REG_CTRL;
        acc_byte[ST_SS] = 1'b1;
      end
      default: ;
    endcase
  end

  // Header shifts out MSB-first and refills with zeros, which become the dummy bytes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      dout_o       <= '0;
      dout_valid_o <= 1'b0;
      hdr_q        <= '0;
      rem_q        <= '0;
      len_q        <= '0;
      poll_q       <= '0;
    end else begin
      busy_o <= state_d != S_IDLE;
      done_o <= state_d == S_DONE;
      if (accept) begin
        err_o <= 1'b0;
        len_q <= len_i;
        rem_q <= CNT_W'(len_i) + CNT_W'(HDR_BYTES);
        hdr_q <= {CMD_READ, addr_i[BYTE_W*ADDR_BYTES-1:0]};
      end
      case (state_q)
        S_TX: begin
          if (acc_ack) begin
            hdr_q  <= {hdr_q[HDR_W-BYTE_W-1:0], BYTE_W'(0)};
            poll_q <= '0;
          end
        end
        S_POLL: begin
          if (acc_ack && rx_empty) begin
            poll_q <= poll_q + POLL_W'(1);
            if (poll_last) begin
              err_o        <= 1'b1;
              dout_valid_o <= 1'b0;
            end
          end
        end
        S_RX: begin
          if (acc_ack) begin
            if (data_phase) begin
              dout_o       <= acc_rdata;
              dout_valid_o <= 1'b1;
            end else begin
              rem_q <= rem_q - CNT_W'(1);
            end
          end
        end
        S_OUT: begin
          if (out_fire) begin
            dout_valid_o <= 1'b0;
            rem_q        <= rem_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  spi_wb_access u_access (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (acc_req),
    .we      (acc_we),
    .adr     (acc_adr),
    .wr_byte (acc_byte),
    .ack     (acc_ack),
    .rdata   (acc_rdata),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_adr_o (m_adr_o),
    .m_we_o  (m_we_o),
    .m_dat_o (m_dat_o),
    .m_sel_o (m_sel_o),
    .m_ack_i (m_ack_i),
    .m_dat_i (m_dat_i)
  );

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural wb_spi + flash model.
module tb_spi_flash_reader;

  logic        clk_i = 1'b0;
  logic        rst_ni, start_i, dout_ready_i;
  logic [31:0] addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, err_o, dout_valid_o;
  logic [7:0]  dout_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic [1:0]  m_adr_o;
  logic [31:0] m_dat_o, m_dat_i;
  logic [3:0]  m_sel_o;

  always #5 clk_i = ~clk_i;

  spi_flash_reader #(.POLL_MAX(15)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .dout_o(dout_o),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_adr_o(m_adr_o), .m_we_o(m_we_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_ack_i(m_ack_i), .m_dat_i(m_dat_i)
  );

  // Slave + flash model: RX byte appears after two status polls unless stalled
  logic        s_ack, ss, rx_valid, stall;
  logic [31:0] s_dat;
  logic [1:0]  pend;
  logic [7:0]  fbyte, rx_byte;
  logic [63:0] mosi_pack;
  int          mosi_cnt, ss_lo_cnt, ss_hi_cnt, polls;
  wire         s_empty = stall || !rx_valid || (pend != 2'd0);

  assign m_ack_i = s_ack;
  assign m_dat_i = s_dat;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_ack <= 1'b0; s_dat <= '0; ss <= 1'b1; rx_valid <= 1'b0; pend <= '0; fbyte <= '0;
      rx_byte <= '0;
    end else begin
      s_ack <= m_stb_o & ~s_ack;
      if (m_stb_o && !s_ack) begin
        if (m_we_o && m_adr_o == 2'd0) begin
          mosi_pack <= {mosi_pack[55:0], m_dat_o[31:24]};
          mosi_cnt  <= mosi_cnt + 1;
          rx_byte   <= (fbyte < 8'd4) ? 8'hFF : 8'(8'hA0 + fbyte - 8'd4);
          rx_valid  <= 1'b1;
          pend      <= 2'd2;
          fbyte     <= fbyte + 8'd1;
          polls     <= 0;
        end else if (m_we_o && m_adr_o == 2'd1) begin
          ss <= m_dat_o[24];
          if (m_dat_o[24]) ss_hi_cnt <= ss_hi_cnt + 1;
          else begin ss_lo_cnt <= ss_lo_cnt + 1; fbyte <= '0; end
        end else if (m_adr_o == 2'd1) begin
          s_dat <= {5'b0, 1'b0, s_empty, ss, 24'h0};
          polls <= polls + 1;
          if (pend != 2'd0) pend <= pend - 2'd1;
        end else begin
          s_dat    <= {rx_byte, 24'h0};
          rx_valid <= 1'b0;
        end
      end
    end
  end

  // Output-side monitors
  logic [31:0] dout_pack;
  int          dout_cnt, done_cnt, stb_cyc, viol;
  logic        prev_ack;
  initial begin
    mosi_pack = '0; mosi_cnt = 0; ss_lo_cnt = 0; ss_hi_cnt = 0; polls = 0;
    dout_pack = '0; dout_cnt = 0; done_cnt = 0; stb_cyc = 0; viol = 0; prev_ack = 1'b0;
  end
  always @(negedge clk_i) begin
    if (dout_valid_o && dout_ready_i) begin
      dout_pack <= {dout_pack[23:0], dout_o};
      dout_cnt  <= dout_cnt + 1;
    end
    if (done_o) done_cnt <= done_cnt + 1;
    if (m_stb_o) stb_cyc <= stb_cyc + 1;
    if (m_stb_o && prev_ack) viol <= viol + 1;
    prev_ack <= m_ack_i;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] l);
    @(posedge clk_i); #1;
    addr_i = a; len_i = l; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_i);
      if (done_o) begin got = 1'b1; break; end
    end
    check(tag, 64'(got), 64'd1);
    @(negedge clk_i);
  endtask

  int   mosi0, dout0, done0, lo0, hi0, tx0;
  logic hit, stable;

  initial begin
    rst_ni = 1'b0; start_i = 1'b0; dout_ready_i = 1'b1; stall = 1'b0;
    addr_i = '0; len_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_valid", 64'(dout_valid_o), 64'd0);
    check("rst_bus", 64'({m_cyc_o, m_stb_o, m_we_o, m_adr_o}), 64'd0);
    check("rst_dat", 64'(m_dat_o), 64'd0);
    check("sel", 64'(m_sel_o), 64'h8);
    rst_ni = 1'b1;
    repeat (100) @(negedge clk_i);
    check("idle_no_stb", 64'(stb_cyc), 64'd0);

    // Zero-length request: done one cycle after start, no bus traffic
    done0 = done_cnt;
    pulse_start(32'h0001_2345, 16'd0);
    @(negedge clk_i);
    check("len0_done", 64'(done_o), 64'd1);
    check("len0_busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    check("len0_done_fall", 64'({done_o, busy_o}), 64'd0);
    check("len0_no_stb", 64'(stb_cyc), 64'd0);

    // Basic 4-byte read
    mosi0 = mosi_cnt; dout0 = dout_cnt; done0 = done_cnt; lo0 = ss_lo_cnt; hi0 = ss_hi_cnt;
    pulse_start(32'h0001_2345, 16'd4);
    wait_done(3000, "rd_done_seen");
    check("rd_mosi_cnt", 64'(mosi_cnt - mosi0), 64'd8);
    check("rd_mosi", mosi_pack, 64'h0301_2345_0000_0000);
    check("rd_dout_cnt", 64'(dout_cnt - dout0), 64'd4);
    check("rd_dout", 64'(dout_pack), 64'hA0A1_A2A3);
    check("rd_ss", 64'({ss_lo_cnt - lo0, ss_hi_cnt - hi0}), {32'd1, 32'd1});
    check("rd_done_cnt", 64'(done_cnt - done0), 64'd1);
    check("rd_end", 64'({busy_o, err_o, ss}), 64'b001);

    // Backpressure on the second data byte
    mosi0 = mosi_cnt; dout0 = dout_cnt;
    pulse_start(32'h0001_2345, 16'd4);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (dout_valid_o && dout_o == 8'hA0) begin hit = 1'b1; break; end
    end
    check("bp_a0_seen", 64'(hit), 64'd1);
    @(posedge clk_i); #1 dout_ready_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_i);
      if (dout_valid_o) begin hit = 1'b1; break; end
    end
    check("bp_a1_valid", 64'(hit), 64'd1);
    tx0 = mosi_cnt; stable = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (!(dout_valid_o && dout_o == 8'hA1)) stable = 1'b0;
    end
    check("bp_hold", 64'(stable), 64'd1);
    check("bp_no_tx", 64'(mosi_cnt - tx0), 64'd0);
    @(posedge clk_i); #1 dout_ready_i = 1'b1;
    wait_done(3000, "bp_done_seen");
    check("bp_dout", 64'(dout_pack), 64'hA0A1_A2A3);
    check("bp_mosi_cnt", 64'(mosi_cnt - mosi0), 64'd8);

    // Start pulse while busy must be ignored
    mosi0 = mosi_cnt; dout0 = dout_cnt; done0 = done_cnt;
    pulse_start(32'h0001_2345, 16'd4);
    repeat (30) @(negedge clk_i);
    check("mid_busy", 64'(busy_o), 64'd1);
    pulse_start(32'h0077_7777, 16'd9);
    wait_done(3000, "mid_done_seen");
    repeat (20) @(negedge clk_i);
    check("mid_dout_cnt", 64'(dout_cnt - dout0), 64'd4);
    check("mid_mosi", mosi_pack, 64'h0301_2345_0000_0000);
    check("mid_mosi_cnt", 64'(mosi_cnt - mosi0), 64'd8);
    check("mid_done_cnt", 64'(done_cnt - done0), 64'd1);
    check("mid_idle", 64'(busy_o), 64'd0);

    // Poll timeout: RX never becomes available
    stall = 1'b1;
    mosi0 = mosi_cnt; dout0 = dout_cnt; done0 = done_cnt; hi0 = ss_hi_cnt;
    pulse_start(32'h0000_0100, 16'd2);
    wait_done(3000, "to_done_seen");
    check("to_err", 64'(err_o), 64'd1);
    check("to_polls", 64'(polls), 64'd15);
    check("to_mosi", 64'({mosi_cnt - mosi0, 24'h0, mosi_pack[7:0]}), {32'd1, 32'h03});
    check("to_ss_hi", 64'({ss_hi_cnt - hi0, 31'h0, ss}), {32'd1, 32'd1});
    check("to_no_dout", 64'({dout_cnt - dout0, 31'h0, dout_valid_o}), 64'd0);
    check("to_done_cnt", 64'(done_cnt - done0), 64'd1);
    stall = 1'b0;
    pulse_start(32'h0000_0010, 16'd1);
    @(negedge clk_i);
    check("to_err_clr", 64'(err_o), 64'd0);
    wait_done(3000, "to2_done_seen");
    check("to2_dout", 64'(dout_pack[7:0]), 64'hA0);
    check("to2_err", 64'(err_o), 64'd0);

    // Reset during the TX phase, then a clean read
    pulse_start(32'h0001_2345, 16'd4);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (m_stb_o && m_we_o && m_adr_o == 2'd0) begin hit = 1'b1; break; end
    end
    check("rt_tx_seen", 64'(hit), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("rt_outs", 64'({m_stb_o, m_cyc_o, busy_o, dout_valid_o}), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mosi0 = mosi_cnt; dout0 = dout_cnt;
    pulse_start(32'h00AB_CDEF, 16'd4);
    wait_done(3000, "rt_done_seen");
    check("rt_mosi", mosi_pack, 64'h03AB_CDEF_0000_0000);
    check("rt_dout", 64'({dout_cnt - dout0, dout_pack}), {32'd4, 32'hA0A1_A2A3});

    check("idle_gap", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- Wishbone master that sequences the SPI peripheral (wb_spi) to perform SPI-flash READ transactions: command byte, address bytes, then N data bytes streamed out.
- Sits between boot/DMA logic (start/addr/len request plus byte stream out) and the wb_spi slave port; sole master of that port while busy.
- Handles chip select, full-duplex RX draining, status polling with timeout, and output backpressure.

Parameters:
- CMD_READ, 8'h03, flash read opcode sent first.
- ADDR_BYTES, 3, number of address bytes sent MSB-first (1..4).
- LEN_W, 16, width of byte-count request.
- POLL_MAX, 1023, status polls per byte before timeout error.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  request pulse; sampled only in IDLE.
- addr_i  in  32  flash byte address; low 8*ADDR_BYTES bits used.
- len_i  in  LEN_W  data bytes to read.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse at completion.
- err_o  out  1  sticky poll-timeout flag; cleared by next accepted start.
- dout_o  out  8  read byte.
- dout_valid_o  out  1  byte valid; held until dout_ready_i.
- dout_ready_i  in  1  consumer accepts byte.
- m_cyc_o, m_stb_o  out  1 each  Wishbone cycle/strobe.
- m_adr_o  out  2  word address: 0 = data, 1 = status/control.
- m_we_o  out  1  write enable.
- m_dat_o  out  32  write data; payload in [31:24].
- m_sel_o  out  4  fixed 4'b1000.
- m_ack_i  in  1  slave ack.
- m_dat_i  in  32  read data; payload in [31:24].

Behaviour:
- Reset (async, rst_ni low): state IDLE; busy_o, done_o, err_o, dout_valid_o, m_cyc_o, m_stb_o, m_we_o = 0; m_adr_o = 0; m_dat_o = 0; counters 0.
- Slave contract: write adr 0 pushes TX byte; read adr 0 pops RX byte; read adr 1 returns {tx_full bit26, rx_empty bit25, ss bit24}; write adr 1 sets ss = dat[24]. Ack arrives one cycle after stb; every TX byte yields one RX byte.
- Bus access: all master outputs registered. stb/cyc rise in cycle n; ack seen in n+1; stb/cyc low in n+2. One idle cycle is mandatory between accesses so the toggling slave ack is never double-counted. Read data captured from m_dat_i[31:24] in the ack cycle.
- FSM: IDLE -> SS_LO (write adr1, dat[24]=0) -> TX (write adr0 with current byte) -> POLL (read adr1, repeat while rx_empty=1) -> RX (read adr0) -> next byte or SS_HI (write adr1, dat[24]=1) -> DONE -> IDLE.
- Byte sequence: CMD_READ, address bytes MSB-first, then len_i dummy bytes 8'h00. RX bytes for command/address are discarded. RX bytes for data phase go to dout_o.
- Data phase: after RX capture, assert dout_valid_o. The next TX is not issued until the handshake completes (valid & ready). dout_o is stable while valid.
- Counters: byte counter LEN_W+3 bits, no wrap; decrements per data byte and SS_HI is entered when it reaches 0. Poll counter resets per byte.
- Timeout: poll count reaching POLL_MAX sets err_o, drops dout_valid_o, goes to SS_HI (ss always released), then DONE.
- len_i = 0: no bus cycles; done_o pulses one cycle after start, busy_o high for that cycle only.
- start_i while busy: ignored. addr_i and len_i are latched on accept.
- done_o pulses in DONE; busy_o falls the same cycle.
- Reset mid-transaction: outputs return to reset values immediately. ss release on the slave is the slave's own reset responsibility.

Decomposition:
- Package spi_flash_pkg: register offsets (REG_DATA=0, REG_CTRL=1), status bit indices (SS=0, RX_EMPTY=1, TX_FULL=2), FSM state encoding, SEL_BYTE3=4'b1000.
- One sub-module: spi_wb_access, a single-access Wishbone master. Inputs: req, we, adr, byte. Outputs: ack pulse and rdata byte. It enforces the stb-drop/idle-cycle rule; the sequencer FSM sits on top.

Test Plan:
- Reset then idle: all outputs 0, no m_stb_o for 100 cycles; start with len=0 -> done_o pulse at +1 cycle, zero bus cycles.
- Read addr=0x012345, len=4 with flash model holding 0xA0..A3 -> MOSI sees 03 01 23 45 00 00 00 00; dout_o sequence A0 A1 A2 A3; ss low->high exactly once; done_o one pulse.
- Same read with dout_ready_i low for 20 cycles on byte 2 -> dout_o holds A1 stable; no TX write issued during the stall; final data correct.
- Slave never clears rx_empty (model stalls) with POLL_MAX=15 -> err_o=1 after 15 polls; ss write 1 observed; done_o pulses; next start clears err_o.
- start_i pulsed while busy mid-read -> ignored; transaction byte count unchanged.
- rst_ni asserted during TX phase -> m_stb_o, busy_o, dout_valid_o low immediately; new start after release completes normally.
